// File: rtl/udp_tx_sched.sv
// Round-robin frame scheduler sharing one UDP transmit port among P_CH channels.
// Define UDP_TX_SCHED_PRIO_EN to give channel 0 strict priority over the round-robin group.
module udp_tx_sched #(
    parameter int unsigned P_CH       = 4,
    parameter int unsigned P_GAP      = 12,
    parameter int unsigned P_START_TO = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [P_CH-1:0]      i_req,
    input  logic [P_CH*16-1:0]   i_len,
    input  logic [P_CH*8-1:0]    i_data,
    input  logic [P_CH-1:0]      i_valid,
    input  logic [P_CH-1:0]      i_last,
    output logic [P_CH-1:0]      o_grant,
    output logic [7:0]           o_send_udp_data,
    output logic [15:0]          o_send_udp_len,
    output logic                 o_send_udp_last,
    output logic                 o_send_udp_valid,
    input  logic                 i_send_ready,
    output logic                 o_busy,
    output logic                 o_timeout,
    output logic                 o_len_err
);

    localparam int unsigned     LP_SW       = (P_CH > 1) ? $clog2(P_CH) : 1;
    localparam logic [9:0]      LP_TO_LAST  = 10'(P_START_TO - 1);
    localparam logic [7:0]      LP_GAP_LAST = 8'(P_GAP);
    localparam logic [P_CH-1:0] LP_ONE      = {{(P_CH-1){1'b0}}, 1'b1};
`ifdef UDP_TX_SCHED_PRIO_EN
    localparam logic [P_CH-1:0] LP_RR_MASK  = ~LP_ONE;
`else
    localparam logic [P_CH-1:0] LP_RR_MASK  = '1;
`endif

    typedef enum logic [1:0] {StIdle, StGrant, StXfer, StGap} state_e;

    state_e           r_state, w_state_nxt;
    logic [LP_SW-1:0] r_sel, w_sel_nxt;
    logic [LP_SW-1:0] r_rr_ptr, w_rr_ptr_nxt;
    logic [P_CH-1:0]  r_grant, w_grant_nxt;
    logic [15:0]      r_len, w_len_nxt;
    logic [15:0]      r_beat_cnt, w_beat_cnt_nxt;
    logic [9:0]       r_to_cnt, w_to_cnt_nxt;
    logic [7:0]       r_gap_cnt, w_gap_cnt_nxt;
    logic [7:0]       r_data, w_data_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_last, w_last_nxt;
    logic             r_timeout, w_timeout_nxt;
    logic             r_len_err, w_len_err_nxt;

    logic             w_pick_found;
    logic [LP_SW-1:0] w_pick;
    logic [31:0]      w_idx;
    logic [LP_SW-1:0] w_idx_s;
    logic [P_CH-1:0]  w_req_rr;
    logic [LP_SW-1:0] w_sel_inc;
    logic [LP_SW-1:0] w_rr_adv;
    logic             w_cur_valid;
    logic             w_cur_last;
    logic [7:0]       w_cur_data;
    logic [15:0]      w_pick_len;

    assign w_cur_valid = i_valid[r_sel];
    assign w_cur_last  = i_last[r_sel];
    assign w_cur_data  = i_data[{r_sel, 3'b000} +: 8];
    assign w_pick_len  = i_len[{w_pick, 4'b0000} +: 16];
    assign w_req_rr    = i_req & LP_RR_MASK;

    assign w_sel_inc = (32'(r_sel) + 32'd1 >= P_CH) ? '0 : r_sel + 1'b1;
`ifdef UDP_TX_SCHED_PRIO_EN
    // Frames on the priority channel leave the round-robin pointer untouched.
    assign w_rr_adv  = (r_sel == '0) ? r_rr_ptr : w_sel_inc;
`else
    assign w_rr_adv  = w_sel_inc;
`endif

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick       = '0;
        w_idx        = '0;
        w_idx_s      = '0;
        for (int unsigned i = 0; i < P_CH; i++) begin
            w_idx = 32'(r_rr_ptr) + i;
            if (w_idx >= P_CH) begin
                w_idx = w_idx - P_CH;
            end
            w_idx_s = LP_SW'(w_idx);
            if (!w_pick_found && w_req_rr[w_idx_s]) begin
                w_pick_found = 1'b1;
                w_pick       = w_idx_s;
            end
        end
`ifdef UDP_TX_SCHED_PRIO_EN
        if (i_req[0]) begin
            w_pick_found = 1'b1;
            w_pick       = '0;
        end
`endif
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_grant_nxt    = r_grant;
        w_len_nxt      = r_len;
        w_beat_cnt_nxt = r_beat_cnt;
        w_to_cnt_nxt   = r_to_cnt;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_data_nxt     = r_data;
        w_valid_nxt    = 1'b0;
        w_last_nxt     = 1'b0;
        w_timeout_nxt  = 1'b0;
        w_len_err_nxt  = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_pick_found && i_send_ready) begin
                    w_sel_nxt      = w_pick;
                    w_grant_nxt    = LP_ONE << w_pick;
                    w_len_nxt      = w_pick_len;
                    w_beat_cnt_nxt = '0;
                    w_to_cnt_nxt   = '0;
                    w_state_nxt    = StGrant;
                end
            end
            StGrant: begin
                if (w_cur_valid) begin
                    w_valid_nxt    = 1'b1;
                    w_data_nxt     = w_cur_data;
                    w_last_nxt     = w_cur_last;
                    w_beat_cnt_nxt = 16'd1;
                    if (w_cur_last) begin
                        w_grant_nxt   = '0;
                        w_rr_ptr_nxt  = w_rr_adv;
                        w_len_err_nxt = (r_len != 16'd1);
                        w_gap_cnt_nxt = '0;
                        w_state_nxt   = StGap;
                    end else begin
                        w_state_nxt   = StXfer;
                    end
                end else if (r_to_cnt == LP_TO_LAST) begin
                    w_grant_nxt   = '0;
                    w_timeout_nxt = 1'b1;
                    w_rr_ptr_nxt  = w_rr_adv;
                    w_gap_cnt_nxt = '0;
                    w_state_nxt   = StGap;
                end else begin
                    w_to_cnt_nxt  = r_to_cnt + 10'd1;
                end
            end
            StXfer: begin
                w_valid_nxt = w_cur_valid;
                w_last_nxt  = w_cur_valid & w_cur_last;
                if (w_cur_valid) begin
                    w_data_nxt     = w_cur_data;
                    w_beat_cnt_nxt = r_beat_cnt + 16'd1;
                    if (w_cur_last) begin
                        w_grant_nxt   = '0;
                        w_rr_ptr_nxt  = w_rr_adv;
                        w_len_err_nxt = ((r_beat_cnt + 16'd1) != r_len);
                        w_gap_cnt_nxt = '0;
                        w_state_nxt   = StGap;
                    end
                end
            end
            StGap: begin
                // GAP spans P_GAP+1 cycles so the next grant lands P_GAP+2 after the last beat.
                if (r_gap_cnt == LP_GAP_LAST) begin
                    w_state_nxt   = StIdle;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_sel      <= '0;
            r_rr_ptr   <= '0;
            r_grant    <= '0;
            r_len      <= '0;
            r_beat_cnt <= '0;
            r_to_cnt   <= '0;
            r_gap_cnt  <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_timeout  <= 1'b0;
            r_len_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_grant    <= w_grant_nxt;
            r_len      <= w_len_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_to_cnt   <= w_to_cnt_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            r_data     <= w_data_nxt;
            r_valid    <= w_valid_nxt;
            r_last     <= w_last_nxt;
            r_timeout  <= w_timeout_nxt;
            r_len_err  <= w_len_err_nxt;
        end
    end

    assign o_grant          = r_grant;
    assign o_send_udp_data  = r_data;
    assign o_send_udp_len   = r_len;
    assign o_send_udp_last  = r_last;
    assign o_send_udp_valid = r_valid;
    assign o_busy           = (r_state != StIdle);
    assign o_timeout        = r_timeout;
    assign o_len_err        = r_len_err;

endmodule
